// File: rtl/rx_arp_parser.sv
// rx_arp_parser: receive-side ARP header parser on an 8-bit AXI-Stream.
// Captures the 28-byte ARP header, validates it, publishes the fields with a
// one-cycle strobe and forwards any trailing bytes through a one-entry output
// register. With arp_enable low at frame start the stream is passed through
// combinationally. Defining RX_ARP_STATS_EN adds saturating frame counters.
module rx_arp_parser #(
  parameter int HDR_BYTES = 28,
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 8
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic        arp_enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] arp_opcode,
  output logic [47:0] arp_srcMac,
  output logic [31:0] arp_srcIP,
  output logic [47:0] arp_destMac,
  output logic [31:0] arp_destIP,
  output logic        arp_valid,
  output logic        arp_error,
  output logic [2:0]  arp_err_code
`ifdef RX_ARP_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err,
  output logic [15:0] stat_req
`endif
);

  localparam int HDR_W = 8 * HDR_BYTES;
  localparam int SH_W  = HDR_W - 8;
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(MAX_BYTES - 1);

  localparam logic [2:0] ERR_HWPROTO  = 3'd1;
  localparam logic [2:0] ERR_LEN      = 3'd2;
  localparam logic [2:0] ERR_OPCODE   = 3'd3;
  localparam logic [2:0] ERR_SHORT    = 3'd4;
  localparam logic [2:0] ERR_ABORT    = 3'd5;
  localparam logic [2:0] ERR_OVERSIZE = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DROP,
    ST_BYPASS
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_user_q, out_user_d;
  logic              out_last_q, out_last_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [2:0]        code_q, code_d;
  logic [15:0]       opcode_q, opcode_d;
  logic [47:0]       sha_q, sha_d;
  logic [31:0]       spa_q, spa_d;
  logic [47:0]       tha_q, tha_d;
  logic [31:0]       tpa_q, tpa_d;
  logic [HDR_W-1:0]  hdr_full;
  logic [2:0]        chk_code;
  logic              bypass;

  // The last header byte completes the shadow; checks look at this full view
  assign hdr_full = {shadow_q, s_axis_tdata};

  // Header validation in priority order: type/proto, lengths, opcode
  always_comb begin
    chk_code = 3'd0;
    if (hdr_full[HDR_W-1 -: 16] != 16'h0001 || hdr_full[HDR_W-17 -: 16] != 16'h0800) begin
      chk_code = ERR_HWPROTO;
    end else if (hdr_full[HDR_W-33 -: 8] != 8'd6 || hdr_full[HDR_W-41 -: 8] != 8'd4) begin
      chk_code = ERR_LEN;
    end else if (hdr_full[HDR_W-49 -: 16] != 16'd1 && hdr_full[HDR_W-49 -: 16] != 16'd2) begin
      chk_code = ERR_OPCODE;
    end
  end

  // Next-state, datapath and handshake logic for every state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    first_d     = first_q;
    out_valid_d = out_valid_q & ~m_axis_tready;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    code_d      = code_q;
    opcode_d    = opcode_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    tha_d       = tha_q;
    tpa_d       = tpa_q;
    bypass      = 1'b0;
    s_axis_tready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rdy_q) begin
          if (!arp_enable) begin
            // Pass-through may only start once the output register is empty
            if (!out_valid_q) begin
              bypass = 1'b1;
              if (s_axis_tvalid && m_axis_tready && s_axis_tuser && !s_axis_tlast) begin
                state_d = ST_BYPASS;
              end
            end
          end else begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tuser) begin
              if (s_axis_tlast) begin
                error_d = 1'b1;
                code_d  = ERR_SHORT;
              end else begin
                shadow_d = {shadow_q[SH_W-9:0], s_axis_tdata};
                cnt_d    = CNT_W'(1);
                state_d  = ST_HEADER;
              end
            end
          end
        end
      end

      ST_HEADER: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          shadow_d = {shadow_q[SH_W-9:0], s_axis_tdata};
          if (s_axis_tuser) begin
            // A new start of frame restarts the header at byte 0
            error_d = 1'b1;
            code_d  = ERR_ABORT;
            if (s_axis_tlast) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end else if (cnt_q == LAST_HDR) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (chk_code == 3'd0) begin
              valid_d  = 1'b1;
              opcode_d = hdr_full[HDR_W-49 -: 16];
              sha_d    = hdr_full[HDR_W-65 -: 48];
              spa_d    = hdr_full[HDR_W-113 -: 32];
              tha_d    = hdr_full[HDR_W-145 -: 48];
              tpa_d    = hdr_full[HDR_W-193 -: 32];
              first_d  = 1'b1;
              state_d  = ST_PAYLOAD;
            end else begin
              error_d = 1'b1;
              code_d  = chk_code;
              state_d = ST_DROP;
            end
            if (s_axis_tlast) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else if (s_axis_tlast) begin
            error_d = 1'b1;
            code_d  = ERR_SHORT;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        s_axis_tready = ~out_valid_q | m_axis_tready;
        if (s_axis_tvalid && (~out_valid_q | m_axis_tready)) begin
          out_valid_d = 1'b1;
          out_data_d  = s_axis_tdata;
          out_user_d  = first_q;
          first_d     = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          out_last_d  = 1'b0;
          if (s_axis_tlast) begin
            out_last_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end else if (cnt_q == LAST_MAX) begin
            // Frame too long: close the output packet here, drop the rest
            out_last_d = 1'b1;
            error_d    = 1'b1;
            code_d     = ERR_OVERSIZE;
            cnt_d      = '0;
            state_d    = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_BYPASS: begin
        bypass = 1'b1;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bypass) begin
      s_axis_tready = m_axis_tready;
    end
    m_axis_tdata  = bypass ? s_axis_tdata  : out_data_q;
    m_axis_tvalid = bypass ? s_axis_tvalid : out_valid_q;
    m_axis_tuser  = bypass ? s_axis_tuser  : out_user_q;
    m_axis_tlast  = bypass ? s_axis_tlast  : out_last_q;
  end

  // State, shadow, output register and published fields
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= '0;
      opcode_q    <= '0;
      sha_q       <= '0;
      spa_q       <= '0;
      tha_q       <= '0;
      tpa_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      code_q      <= code_d;
      opcode_q    <= opcode_d;
      sha_q       <= sha_d;
      spa_q       <= spa_d;
      tha_q       <= tha_d;
      tpa_q       <= tpa_d;
    end
  end

  assign arp_opcode   = opcode_q;
  assign arp_srcMac   = sha_q;
  assign arp_srcIP    = spa_q;
  assign arp_destMac  = tha_q;
  assign arp_destIP   = tpa_q;
  assign arp_valid    = valid_q;
  assign arp_error    = error_q;
  assign arp_err_code = code_q;

`ifdef RX_ARP_STATS_EN
  logic [15:0] stat_ok_q, stat_err_q, stat_req_q;

  // Saturating frame counters driven by the registered strobes
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
      stat_req_q <= '0;
    end else begin
      if (valid_q && stat_ok_q != 16'hFFFF) begin
        stat_ok_q <= stat_ok_q + 16'd1;
      end
      if (error_q && stat_err_q != 16'hFFFF) begin
        stat_err_q <= stat_err_q + 16'd1;
      end
      if (valid_q && opcode_q == 16'd1 && stat_req_q != 16'hFFFF) begin
        stat_req_q <= stat_req_q + 16'd1;
      end
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
  assign stat_req = stat_req_q;
`endif

endmodule
